// File: rtl/branch_flush_controller_pkg.sv
// Shared definitions for the branch/flush sequencer.
// Holds the 2-bit controller state encodings and a helper that converts a
// flush depth into the value the flush counter loads when a redirect issues.
package branch_flush_controller_pkg;

    localparam logic [1:0] BFC_RUN    = 2'd0;
    localparam logic [1:0] BFC_FLUSH  = 2'd1;
    localparam logic [1:0] BFC_PEND   = 2'd2;
    localparam logic [1:0] BFC_HALTED = 2'd3;

    // The redirect cycle itself squashes one slot, so the FLUSH state only
    // covers the remaining depth-1 slots.
    function automatic logic [2:0] flush_load(input int unsigned depth);
        return 3'(depth - 1);
    endfunction

endpackage

// File: rtl/branch_flush_controller_sat_counter.sv
// Saturating up-counter, reusable for performance counters.
// Ports:
//   Clk      in   core clock
//   Reset_N  in   synchronous active-low reset, clears count
//   inc      in   increment request for this cycle
//   count    out  current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset_N,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_flush_controller.sv
// PC redirection and pipeline flush/stall sequencer for a 5-stage RV32I core.
// Ports:
//   Clk, Reset_N     clock, synchronous active-low reset
//   Branch_And, Jump EX-stage taken branch / JAL(R); Target_PC is their target
//   Load_Use_Haz     ID-stage load-use hazard (stalls PC and IF/ID)
//   Fetch_Ready      instruction memory can accept a new PC this cycle
//   Halt             ECALL/EBREAK/FENCE in EX, stops fetch until reset
//   PC_Src, PC_Write, Redirect_PC   PC mux select, PC enable, redirect target
//   IF_ID_Write, IF_ID_Flush, ID_EX_Flush  pipeline register controls
//   Halted           core halted
//   Redirect_Count   saturating count of redirects issued
// FLUSH_DEPTH is legal in 1..4.
import branch_flush_controller_pkg::*;

module branch_flush_controller #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             Branch_And,
    input  logic             Jump,
    input  logic [PC_W-1:0]  Target_PC,
    input  logic             Load_Use_Haz,
    input  logic             Fetch_Ready,
    input  logic             Halt,
    output logic             PC_Src,
    output logic             PC_Write,
    output logic [PC_W-1:0]  Redirect_PC,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Halted,
    output logic [CNT_W-1:0] Redirect_Count
);

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [2:0]      flush_cnt;
    logic [2:0]      flush_cnt_nx;
    logic [PC_W-1:0] held_pc;
    logic            latch_target;
    logic            issue;
    logic            redir;

    assign redir = Branch_And | Jump;

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state     <= BFC_RUN;
            flush_cnt <= '0;
            held_pc   <= '0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
            if (latch_target) begin
                held_pc <= Target_PC;
            end
        end
    end

    always_comb begin
        PC_Src       = 1'b0;
        PC_Write     = 1'b1;
        // Selected on state only, keeping Fetch_Ready off this path.
        Redirect_PC  = (state == BFC_PEND) ? held_pc : Target_PC;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        Halted       = 1'b0;
        issue        = 1'b0;
        latch_target = 1'b0;
        state_nx     = state;
        flush_cnt_nx = flush_cnt;

        // While reset is held the outputs present the RUN/no-request values
        // regardless of the current state or any request on the inputs.
        if (Reset_N) begin
            case (state)
                BFC_RUN: begin
                    if (Halt) begin
                        PC_Write    = 1'b0;
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        state_nx    = BFC_HALTED;
                    end else if (redir) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        if (Fetch_Ready) begin
                            PC_Src = 1'b1;
                            issue  = 1'b1;
                        end else begin
                            PC_Write     = 1'b0;
                            latch_target = 1'b1;
                            state_nx     = BFC_PEND;
                        end
                    end else if (Load_Use_Haz) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end else begin
                        PC_Write = Fetch_Ready;
                    end
                end
                BFC_FLUSH: begin
                    ID_EX_Flush = 1'b1;
                    if (Halt) begin
                        PC_Write    = 1'b0;
                        IF_ID_Flush = 1'b1;
                        state_nx    = BFC_HALTED;
                    end else begin
                        PC_Write = Fetch_Ready;
                        if (flush_cnt <= 3'd1) begin
                            flush_cnt_nx = '0;
                            state_nx     = BFC_RUN;
                        end else begin
                            flush_cnt_nx = flush_cnt - 3'd1;
                        end
                    end
                end
                BFC_PEND: begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    if (Halt) begin
                        PC_Write = 1'b0;
                        state_nx = BFC_HALTED;
                    end else if (Fetch_Ready) begin
                        PC_Src = 1'b1;
                        issue  = 1'b1;
                    end else begin
                        PC_Write = 1'b0;
                    end
                end
                default: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    Halted      = 1'b1;
                end
            endcase

            if (issue) begin
                if (FLUSH_DEPTH <= 1) begin
                    state_nx     = BFC_RUN;
                    flush_cnt_nx = '0;
                end else begin
                    state_nx     = BFC_FLUSH;
                    flush_cnt_nx = flush_load(FLUSH_DEPTH);
                end
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_redirect_cnt (
        .Clk    (Clk),
        .Reset_N(Reset_N),
        .inc    (issue),
        .count  (Redirect_Count)
    );

endmodule

// File: tb/tb_branch_flush_controller.sv
// Scoreboard bench for branch_flush_controller: the stimulus process computes
// each cycle's expected outputs from a behavioural model and queues them; a
// monitor on the falling edge pops and compares against the DUT.
module tb_branch_flush_controller;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned FD    = 2;
    localparam int unsigned CNT_W = 3;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rn, ba, jp, lu, fr, ht;
    logic [PC_W-1:0]  tgt;
    logic             pc_src, pc_write, if_id_write, if_id_flush, id_ex_flush, halted;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] redirect_count;

    always #5 clk = ~clk;

    branch_flush_controller #(
        .PC_W       (PC_W),
        .FLUSH_DEPTH(FD),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk           (clk),
        .Reset_N       (rn),
        .Branch_And    (ba),
        .Jump          (jp),
        .Target_PC     (tgt),
        .Load_Use_Haz  (lu),
        .Fetch_Ready   (fr),
        .Halt          (ht),
        .PC_Src        (pc_src),
        .PC_Write      (pc_write),
        .Redirect_PC   (redirect_pc),
        .IF_ID_Write   (if_id_write),
        .IF_ID_Flush   (if_id_flush),
        .ID_EX_Flush   (id_ex_flush),
        .Halted        (halted),
        .Redirect_Count(redirect_count)
    );

    typedef struct packed {
        logic             pc_src;
        logic             pc_write;
        logic [PC_W-1:0]  rpc;
        logic             rpc_care;
        logic             if_id_write;
        logic             if_id_flush;
        logic             id_ex_flush;
        logic             halted;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Behavioural model: pipeline situation described by flags and counts.
    bit              m_halted   = 0;
    bit              m_pending  = 0;
    logic [PC_W-1:0] m_target   = '0;
    int              m_flush_left = 0;
    int              m_count    = 0;

    function automatic exp_t model_out();
        exp_t e;
        e.pc_src = 0; e.pc_write = 1; e.rpc = tgt; e.rpc_care = 0;
        e.if_id_write = 1; e.if_id_flush = 0; e.id_ex_flush = 0; e.halted = 0;
        e.cnt = CNT_W'(m_count);
        if (!rn) return e;
        if (m_halted) begin
            e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1; e.halted = 1;
        end else if (m_pending) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
            e.rpc = m_target; e.rpc_care = 1;
            e.pc_src = fr && !ht; e.pc_write = fr && !ht;
        end else if (m_flush_left > 0) begin
            e.id_ex_flush = 1; e.pc_write = fr;
        end else if (ht) begin
            e.pc_write = 0; e.if_id_flush = 1; e.id_ex_flush = 1;
        end else if (ba || jp) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
            e.pc_src = fr; e.pc_write = fr; e.rpc_care = 1;
        end else if (lu) begin
            e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1;
        end else begin
            e.pc_write = fr;
        end
        return e;
    endfunction

    function automatic void count_redirect();
        if (m_count < CMAX) m_count++;
        m_flush_left = FD - 1;
    endfunction

    function automatic void model_update();
        if (!rn) begin
            m_halted = 0; m_pending = 0; m_target = '0; m_flush_left = 0; m_count = 0;
        end else if (m_halted) begin
            // stays halted
        end else if (m_pending) begin
            if (ht) begin
                m_halted = 1; m_pending = 0;
            end else if (fr) begin
                m_pending = 0; count_redirect();
            end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (ht) begin
            m_halted = 1;
        end else if (ba || jp) begin
            if (fr) count_redirect();
            else begin
                m_pending = 1; m_target = tgt;
            end
        end
    endfunction

    task automatic step(input bit r, input bit b, input bit j, input logic [PC_W-1:0] t,
                        input bit l, input bit f, input bit h);
        rn = r; ba = b; jp = j; tgt = t; lu = l; fr = f; ht = h;
        q.push_back(model_out());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_src", 32'(pc_src), 32'(e.pc_src));
            chk("pc_write", 32'(pc_write), 32'(e.pc_write));
            if (e.rpc_care) chk("redirect_pc", redirect_pc, e.rpc);
            chk("if_id_write", 32'(if_id_write), 32'(e.if_id_write));
            chk("if_id_flush", 32'(if_id_flush), 32'(e.if_id_flush));
            chk("id_ex_flush", 32'(id_ex_flush), 32'(e.id_ex_flush));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("redirect_count", 32'(redirect_count), 32'(e.cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rn = 0; ba = 0; jp = 0; lu = 0; fr = 1; ht = 0; tgt = '0;
        @(posedge clk); #1;

        // Reset held with a branch request present.
        step(0, 1, 0, 32'h0, 0, 1, 0);
        step(0, 1, 0, 32'h0, 0, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1, 0);

        // Zero-latency branch redirect, then one flush slot, then RUN.
        step(1, 1, 0, 32'h40, 0, 1, 0);
        step(1, 1, 0, 32'h44, 0, 1, 0);
        step(1, 0, 0, 32'h48, 0, 1, 0);

        // Jump held pending while fetch not ready; latched target survives.
        step(1, 0, 1, 32'h80, 0, 0, 0);
        step(1, 0, 0, 32'h99, 0, 0, 0);
        step(1, 0, 1, 32'h99, 0, 0, 0);
        step(1, 0, 0, 32'h99, 0, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1, 0);

        // Load-use stall two cycles, then redirect beats the hazard.
        step(1, 0, 0, 32'h0, 1, 1, 0);
        step(1, 0, 0, 32'h0, 1, 1, 0);
        step(1, 1, 0, 32'h100, 1, 1, 0);
        step(1, 0, 0, 32'h0, 1, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1, 0);

        // Halt beats a branch; stays halted until reset.
        step(1, 1, 0, 32'h200, 0, 1, 1);
        step(1, 1, 0, 32'h200, 1, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1, 1);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1, 0);

        // Halt while a redirect is pending discards it.
        step(1, 1, 0, 32'h300, 0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 1, 1);
        step(1, 0, 0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 1, 0);

        // Branch held high: only RUN-cycle requests count; counter saturates.
        for (int i = 0; i < 24; i++) step(1, 1, 0, 32'(i * 4), 0, 1, 0);
        step(1, 0, 0, 32'h0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, h;
            r = m_halted ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) != 0);
            h = (m_flush_left == 0) && ($urandom_range(0, 39) == 0);
            step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, h);
        end

        ba = 0; jp = 0; ht = 0; lu = 0;
        @(negedge clk); #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
